bit_32_serial_subtractor_8: RTL and testbench

BIT_32_SERIAL_SUBTRACTOR_8 -- requirements
Module: bit_32_serial_subtractor_8

---
 rtl/bit_32_serial_subtractor_8.sv | 114 +++++++++++
 tb/tb_bit_32_serial_subtractor_8.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/bit_32_serial_subtractor_8.sv
// 32-bit subtractor that works one 8-bit slice per cycle (A + ~B + 1), with a
// valid/ready handshake on both sides and flags latched when the result completes.
module bit_32_serial_subtractor_8 (
  input  logic        CLK_in,
  input  logic        RST_in,
  input  logic [31:0] A_in,
  input  logic [31:0] B_in,
  input  logic        valid_in,
  output logic        ready_out,
  output logic [31:0] D_out,
  output logic        B_out,
  output logic        Z_out,
  output logic        N_out,
  output logic        V_out,
  output logic        LT_out,
  output logic        LTU_out,
  output logic        valid_out,
  input  logic        ready_in
);
  localparam int SLICE_W    = 8;
  localparam int NUM_SLICES = 4;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                                r_state;
  logic [NUM_SLICES-1:0][SLICE_W-1:0]    r_a;
  logic [NUM_SLICES-1:0][SLICE_W-1:0]    r_nb;
  logic [NUM_SLICES-1:0][SLICE_W-1:0]    r_d;
  logic [1:0]                            r_cnt;
  logic                                  r_carry;
  logic                                  r_ready;
  logic                                  r_valid;
  logic [31:0]                           r_dout;
  logic                                  r_b, r_z, r_n, r_v, r_lt, r_ltu;

  logic [SLICE_W:0] w_sum;
  logic [31:0]      w_dfull;
  logic             w_borrow;
  logic             w_ovf;

  assign w_sum    = {1'b0, r_a[r_cnt]} + {1'b0, r_nb[r_cnt]} + {{SLICE_W{1'b0}}, r_carry};
  // Only meaningful on the last slice: top byte comes straight from the adder.
  assign w_dfull  = {w_sum[SLICE_W-1:0], r_d[2], r_d[1], r_d[0]};
  assign w_borrow = ~w_sum[SLICE_W];
  // r_nb holds ~B, so B[31] != A[31] becomes r_nb[31] == A[31].
  assign w_ovf    = (r_nb[3][7] == r_a[3][7]) && (w_dfull[31] != r_a[3][7]);

  always_ff @(posedge CLK_in) begin
    if (RST_in) begin
      r_state <= IDLE;
      r_ready <= 1'b1;
      r_valid <= 1'b0;
      r_a     <= '0;
      r_nb    <= '0;
      r_d     <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_dout  <= '0;
      r_b     <= 1'b0;
      r_z     <= 1'b0;
      r_n     <= 1'b0;
      r_v     <= 1'b0;
      r_lt    <= 1'b0;
      r_ltu   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (valid_in) begin
          r_a     <= A_in;
          r_nb    <= ~B_in;
          r_carry <= 1'b1;
          r_cnt   <= '0;
          r_ready <= 1'b0;
          r_state <= CALC;
        end
        CALC: begin
          r_d[r_cnt] <= w_sum[SLICE_W-1:0];
          r_carry    <= w_sum[SLICE_W];
          r_cnt      <= r_cnt + 2'd1;
          if (r_cnt == 2'd3) begin
            r_state <= DONE;
            r_valid <= 1'b1;
            r_dout  <= w_dfull;
            r_b     <= w_borrow;
            r_ltu   <= w_borrow;
            r_z     <= (w_dfull == 32'd0);
            r_n     <= w_dfull[31];
            r_v     <= w_ovf;
            r_lt    <= w_dfull[31] ^ w_ovf;
          end
        end
        DONE: if (ready_in) begin
          r_valid <= 1'b0;
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
        default: begin
          r_valid <= 1'b0;
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign ready_out = r_ready;
  assign valid_out = r_valid;
  assign D_out     = r_dout;
  assign B_out     = r_b;
  assign Z_out     = r_z;
  assign N_out     = r_n;
  assign V_out     = r_v;
  assign LT_out    = r_lt;
  assign LTU_out   = r_ltu;
endmodule

// File: tb/tb_bit_32_serial_subtractor_8.sv
// Directed bench for the serial subtractor: vector table plus backpressure and
// mid-operation reset sequences. Flags are compared as {B,Z,N,V,LT,LTU}.
module tb_bit_32_serial_subtractor_8;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a_in, b_in;
  logic        valid_in, ready_in;
  logic        ready_out, valid_out;
  logic [31:0] d_out;
  logic        b_out, z_out, n_out, v_out, lt_out, ltu_out;

  int tests = 0;
  int fails = 0;

  bit_32_serial_subtractor_8 dut (
    .CLK_in(clk), .RST_in(rst), .A_in(a_in), .B_in(b_in), .valid_in(valid_in),
    .ready_out(ready_out), .D_out(d_out), .B_out(b_out), .Z_out(z_out),
    .N_out(n_out), .V_out(v_out), .LT_out(lt_out), .LTU_out(ltu_out),
    .valid_out(valid_out), .ready_in(ready_in)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] d;
    logic [5:0]  f;
    logic        hold_rdy;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [5:0] flags();
    return {b_out, z_out, n_out, v_out, lt_out, ltu_out};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Accept one op, check latency and result; leaves the block in DONE.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic hold_rdy,
                          input string tag);
    int lat;
    bit seen;
    @(negedge clk);
    a_in = a; b_in = b; valid_in = 1'b1; ready_in = hold_rdy;
    tick();
    chk({tag, " ready_out after accept"}, {31'd0, ready_out}, 32'd0);
    valid_in = 1'b0; a_in = ~a; b_in = a ^ 32'h5A5A_5A5A;
    seen = 1'b0;
    lat = 0;
    for (int i = 1; i <= 12 && !seen; i++) begin
      tick();
      lat = i;
      if (valid_out) seen = 1'b1;
    end
    if (!seen) lat = 99;
    chk({tag, " latency"}, lat, 32'd4);
  endtask

  task automatic release_op(input string tag);
    @(negedge clk);
    ready_in = 1'b1;
    tick();
    chk({tag, " idle valid/ready"}, {30'd0, valid_out, ready_out}, 32'd1);
    ready_in = 1'b0;
  endtask

  initial begin
    vecs[0] = '{32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 6'b000000, 1'b1};
    vecs[1] = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 6'b101011, 1'b0};
    vecs[2] = '{32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 6'b000110, 1'b0};
    vecs[3] = '{32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 6'b010000, 1'b0};
    vecs[4] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 6'b101101, 1'b0};
    vecs[5] = '{32'h0000_0100, 32'h0000_0001, 32'h0000_00FF, 6'b000000, 1'b1};
    vecs[6] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 6'b001010, 1'b0};
    vecs[7] = '{32'h0001_0000, 32'h0000_FFFF, 32'h0000_0001, 6'b000000, 1'b0};

    rst = 1'b1; a_in = '0; b_in = '0; valid_in = 1'b0; ready_in = 1'b0;
    tick(); tick();
    chk("reset ready/valid", {30'd0, ready_out, valid_out}, 32'd2);
    chk("reset D_out", d_out, 32'd0);
    chk("reset flags", {26'd0, flags()}, 32'd0);
    @(negedge clk); rst = 1'b0;

    foreach (vecs[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      start_op(vecs[i].a, vecs[i].b, vecs[i].hold_rdy, tag);
      chk({tag, " D_out"}, d_out, vecs[i].d);
      chk({tag, " flags"}, {26'd0, flags()}, {26'd0, vecs[i].f});
      release_op(tag);
      chk({tag, " D_out held in idle"}, d_out, vecs[i].d);
    end

    // Backpressure: result holds for 10 cycles, new offers ignored.
    start_op(32'h0000_000A, 32'h0000_0003, 1'b0, "bp");
    @(negedge clk);
    a_in = 32'hDEAD_BEEF; b_in = 32'h0000_0001; valid_in = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("bp D_out stable", d_out, 32'h0000_0007);
      chk("bp flags stable", {26'd0, flags()}, 32'd0);
      chk("bp valid/ready", {30'd0, valid_out, ready_out}, 32'd2);
    end
    @(negedge clk);
    valid_in = 1'b0; ready_in = 1'b1;
    tick();
    chk("bp exit valid/ready", {30'd0, valid_out, ready_out}, 32'd1);
    chk("bp D_out after exit", d_out, 32'h0000_0007);
    ready_in = 1'b0;

    // Reset during the second CALC cycle aborts the op with no valid pulse.
    @(negedge clk);
    a_in = 32'h0000_0000; b_in = 32'h0000_0001; valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    tick();
    @(negedge clk); rst = 1'b1;
    tick();
    @(negedge clk); rst = 1'b0;
    chk("rst-mid ready/valid", {30'd0, ready_out, valid_out}, 32'd2);
    chk("rst-mid D_out", d_out, 32'd0);
    chk("rst-mid flags", {26'd0, flags()}, 32'd0);
    begin
      int pulses;
      pulses = 0;
      for (int c = 0; c < 6; c++) begin
        tick();
        if (valid_out) pulses++;
      end
      chk("rst-mid no valid pulse", pulses, 32'd0);
    end
    start_op(32'h0000_0009, 32'h0000_0004, 1'b0, "post-rst");
    chk("post-rst D_out", d_out, 32'h0000_0005);
    chk("post-rst flags", {26'd0, flags()}, 32'd0);
    release_op("post-rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
